pipo_load_arbiter: RTL and testbench
====================================

PIPO_LOAD_ARBITER -- requirements
Module: pipo_load_arbiter

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8: width of the shared parallel register and both data inputs.
REQ-002 SHALL have parameter HOLD_CYCLES, default 2, legal range 1..255: number of clock edges the loaded value is held before release.
REQ-003 SHALL have port Clk_In  input  1  single clock; all state changes on its falling edge.
REQ-004 SHALL have port Reset_In  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port Req_In  input  2  request, bit n from requester n; level-sensitive.
REQ-006 SHALL have port Data0_In  input  DATA_WIDTH  parallel data from requester 0.
REQ-007 SHALL have port Data1_In  input  DATA_WIDTH  parallel data from requester 1.
REQ-008 SHALL have port Grant_Out  output  2  one-hot grant, zero when idle.
REQ-009 SHALL have port Parallel_Data_Out  output  DATA_WIDTH  shared register contents.
REQ-010 SHALL have port Owner_Out  output  1  index of the requester that last loaded the register.
REQ-011 SHALL have port Busy_Out  output  1  high whenever state is not IDLE.
REQ-012 SHALL have port Done_Out  output  1  one-cycle pulse marking transaction end.

Function
REQ-013 SHALL implement the FSM states IDLE, LOAD and HOLD, all registered on negedge Clk_In.
REQ-014 SHALL sample Req_In only in IDLE; at an edge with any Req_In bit high, it SHALL set Grant_Out one-hot to the winner and go to LOAD.
REQ-015 SHALL stay in IDLE with Grant_Out=0 at an IDLE edge with Req_In=2'b00.
REQ-016 SHALL, at the LOAD edge, capture the winner's data into Parallel_Data_Out, set Owner_Out to the winner index, load hold counter with HOLD_CYCLES-1, and go to HOLD.
REQ-017 SHALL decrement the counter at each HOLD edge; at the edge where counter==0 it SHALL clear Grant_Out, pulse Done_Out high for exactly one cycle, and return to IDLE.
REQ-018 SHALL give a latency from the granting edge to data valid of 1 edge, and a transaction length of HOLD_CYCLES+1 edges from grant to Done_Out.
REQ-019 SHALL complete a transaction once granted even if Req_In falls in LOAD or HOLD; there is no abort.
REQ-020 SHALL spend at least one edge in IDLE between transactions, so back-to-back grants are separated by one IDLE edge.
REQ-021 SHALL hold Parallel_Data_Out and Owner_Out unchanged outside the LOAD edge.
REQ-022 SHALL drive Busy_Out as a combinational decode of the registered state only.

Reset
REQ-023 SHALL, while Reset_In is high and regardless of clock, force state=IDLE, Grant_Out=0, Parallel_Data_Out=0, Owner_Out=0, Done_Out=0, counter=0, and round-robin pointer=0.
REQ-024 SHALL, on reset mid-transaction, abandon the transaction with no Done_Out pulse.
REQ-025 SHALL first arbitrate at the first falling edge after Reset_In deasserts.

Configuration
REQ-026 SHALL, with macro PIPO_ARB_ROUND_ROBIN_EN defined, resolve simultaneous requests to the requester selected by a 1-bit pointer; the pointer resets to 0 and is set to the non-winner at each grant.
REQ-027 SHALL, without PIPO_ARB_ROUND_ROBIN_EN, use fixed priority with requester 0 always winning simultaneous requests and no pointer logic.
REQ-028 SHALL grant a lone requester immediately in both configurations.

Structure
REQ-029 SHALL take the state encoding (IDLE=2'd0, LOAD=2'd1, HOLD=2'd2) and the default DATA_WIDTH and HOLD_CYCLES constants from shared package pipo_arb_pkg.
REQ-030 SHALL place the shared register in sub-module pipo_data_reg (negedge, async reset, load enable, DATA_WIDTH wide); the arbitration FSM stays in the top level.

Verification
REQ-031 SHALL have a bench scenario: reset, Req_In=01, Data0_In=8'hA5 -> Grant_Out=01 next edge, Parallel_Data_Out=8'hA5 and Owner_Out=0 one edge later, Done_Out pulse 3 edges after grant (HOLD_CYCLES=2).
REQ-032 SHALL have a bench scenario: Req_In=11 continuous, Data0_In=8'h11, Data1_In=8'h22, round-robin build -> grants alternate 01,10,01 and data alternates 11,22,11.
REQ-033 SHALL have a bench scenario: the same stimulus as REQ-032 on the fixed-priority build -> every grant is 01 and data stays 8'h11.
REQ-034 SHALL have a bench scenario: Req_In=10 dropped to 00 in HOLD -> transaction completes, Done_Out pulses, Parallel_Data_Out holds Data1_In.
REQ-035 SHALL have a bench scenario: Reset_In pulsed mid-HOLD between clock edges -> outputs zero immediately, no Done_Out pulse, and the next grant goes to requester 0.
REQ-036 SHALL have a bench scenario: HOLD_CYCLES=1 with continuous Req_In=01 -> grant period of 3 edges (grant, load, done) with one IDLE edge between transactions.

Source files
------------

// File: rtl/pipo_arb_pkg.sv
// Shared constants, FSM state encoding and grant helper for the PIPO load arbiter.
package pipo_arb_pkg;

    localparam int DEF_DATA_WIDTH  = 8;
    localparam int DEF_HOLD_CYCLES = 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_HOLD = 2'd2
    } state_e;

    function automatic logic [1:0] grant_onehot(input logic idx);
        return idx ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/pipo_data_reg.sv
// Shared parallel register: falling-edge, async reset, loads only when enabled.
module pipo_data_reg
    import pipo_arb_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load_en,
    input  logic [DATA_WIDTH-1:0] data_d,
    output logic [DATA_WIDTH-1:0] data_q
);

    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            data_q <= '0;
        end else if (load_en) begin
            data_q <= data_d;
        end
    end

endmodule

// File: rtl/pipo_load_arbiter.sv
// Two-requester arbiter owning a shared parallel register (IDLE -> LOAD -> HOLD).
// Define PIPO_ARB_ROUND_ROBIN_EN for round-robin tie-break; default is fixed priority (requester 0).
module pipo_load_arbiter
    import pipo_arb_pkg::*;
#(
    parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter int HOLD_CYCLES = DEF_HOLD_CYCLES
) (
    input  logic                  Clk_In,
    input  logic                  Reset_In,
    input  logic [1:0]            Req_In,
    input  logic [DATA_WIDTH-1:0] Data0_In,
    input  logic [DATA_WIDTH-1:0] Data1_In,
    output logic [1:0]            Grant_Out,
    output logic [DATA_WIDTH-1:0] Parallel_Data_Out,
    output logic                  Owner_Out,
    output logic                  Busy_Out,
    output logic                  Done_Out
);

    localparam logic [7:0] HOLD_LOAD = 8'(HOLD_CYCLES - 1);

    state_e     state_q, state_d;
    logic [1:0] grant_q, grant_d;
    logic       owner_q, owner_d;
    logic       done_q,  done_d;
    logic [7:0] cnt_q,   cnt_d;
    logic       winner;
`ifdef PIPO_ARB_ROUND_ROBIN_EN
    logic       ptr_q,   ptr_d;
`endif

    // A lone requester always wins; only a tie consults the pointer (or requester 0).
    always_comb begin
`ifdef PIPO_ARB_ROUND_ROBIN_EN
        winner = (Req_In == 2'b11) ? ptr_q : Req_In[1];
`else
        winner = ~Req_In[0];
`endif
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        owner_d = owner_q;
        done_d  = 1'b0;
        cnt_d   = cnt_q;
`ifdef PIPO_ARB_ROUND_ROBIN_EN
        ptr_d   = ptr_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (|Req_In) begin
                    grant_d = grant_onehot(winner);
                    state_d = ST_LOAD;
`ifdef PIPO_ARB_ROUND_ROBIN_EN
                    ptr_d   = ~winner;
`endif
                end
            end
            ST_LOAD: begin
                owner_d = grant_q[1];
                cnt_d   = HOLD_LOAD;
                state_d = ST_HOLD;
            end
            ST_HOLD: begin
                if (cnt_q == 8'd0) begin
                    grant_d = 2'b00;
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            default: begin
                grant_d = 2'b00;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(negedge Clk_In or posedge Reset_In) begin
        if (Reset_In) begin
            state_q <= ST_IDLE;
            grant_q <= 2'b00;
            owner_q <= 1'b0;
            done_q  <= 1'b0;
            cnt_q   <= 8'd0;
`ifdef PIPO_ARB_ROUND_ROBIN_EN
            ptr_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            owner_q <= owner_d;
            done_q  <= done_d;
            cnt_q   <= cnt_d;
`ifdef PIPO_ARB_ROUND_ROBIN_EN
            ptr_q   <= ptr_d;
`endif
        end
    end

    pipo_data_reg #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_data_reg (
        .clk    (Clk_In),
        .rst    (Reset_In),
        .load_en(state_q == ST_LOAD),
        .data_d (grant_q[1] ? Data1_In : Data0_In),
        .data_q (Parallel_Data_Out)
    );

    assign Grant_Out = grant_q;
    assign Owner_Out = owner_q;
    assign Done_Out  = done_q;
    assign Busy_Out  = (state_q != ST_IDLE);

endmodule

// File: tb/tb_pipo_load_arbiter.sv
// Directed bench for pipo_load_arbiter with a transaction scoreboard; expectations follow
// PIPO_ARB_ROUND_ROBIN_EN the same way the design build does.
module tb_pipo_load_arbiter;

    localparam int H = 2;

    typedef struct packed {
        logic [1:0] grant;
        logic [7:0] data;
        logic       owner;
    } exp_t;

    logic       Clk = 1'b1;
    logic       Reset_In;
    logic [1:0] Req_In;
    logic [7:0] Data0_In, Data1_In;
    logic [1:0] Grant_Out;
    logic [7:0] Parallel_Data_Out;
    logic       Owner_Out, Busy_Out, Done_Out;

    logic [1:0] req1;
    logic [7:0] d1_0, d1_1;
    logic [1:0] grant1;
    logic [7:0] data1;
    logic       owner1, busy1, done1;

    int   n_cmp  = 0;
    int   n_fail = 0;
    exp_t sbq[$];
    logic m_ptr = 1'b0;

    always #5 Clk = ~Clk;

    pipo_load_arbiter #(.DATA_WIDTH(8), .HOLD_CYCLES(H)) dut (
        .Clk_In(Clk), .Reset_In(Reset_In), .Req_In(Req_In),
        .Data0_In(Data0_In), .Data1_In(Data1_In),
        .Grant_Out(Grant_Out), .Parallel_Data_Out(Parallel_Data_Out),
        .Owner_Out(Owner_Out), .Busy_Out(Busy_Out), .Done_Out(Done_Out)
    );

    pipo_load_arbiter #(.DATA_WIDTH(8), .HOLD_CYCLES(1)) dut1 (
        .Clk_In(Clk), .Reset_In(Reset_In), .Req_In(req1),
        .Data0_In(d1_0), .Data1_In(d1_1),
        .Grant_Out(grant1), .Parallel_Data_Out(data1),
        .Owner_Out(owner1), .Busy_Out(busy1), .Done_Out(done1)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge Clk);
        #1;
    endtask

    task automatic pick(input logic [1:0] req, output logic w);
`ifdef PIPO_ARB_ROUND_ROBIN_EN
        w = (req == 2'b11) ? m_ptr : req[1];
        m_ptr = ~w;
`else
        w = ~req[0];
`endif
    endtask

    task automatic push_exp(input logic [1:0] req);
        logic w;
        exp_t e;
        pick(req, w);
        e.grant = w ? 2'b10 : 2'b01;
        e.data  = w ? Data1_In : Data0_In;
        e.owner = w;
        sbq.push_back(e);
    endtask

    task automatic sb_check(input string tag);
        exp_t e;
        if (sbq.size() == 0) begin
            n_cmp++;
            n_fail++;
            $error("FAIL %s: observed empty scoreboard expected one entry", tag);
        end else begin
            e = sbq.pop_front();
            check({tag, "_grant"}, 32'(Grant_Out), 32'(e.grant));
            check({tag, "_data"},  32'(Parallel_Data_Out), 32'(e.data));
            check({tag, "_owner"}, 32'(Owner_Out), 32'(e.owner));
        end
    endtask

    // drop_after: 0 keeps the request, 1 drops it in LOAD, 2 drops it in HOLD
    task automatic txn(input string tag, input logic [1:0] req, input logic [7:0] d0,
                       input logic [7:0] d1, input int drop_after);
        Req_In = req; Data0_In = d0; Data1_In = d1;
        push_exp(req);
        step();
        check({tag, "_grant_edge_done"}, 32'(Done_Out), 32'd0);
        check({tag, "_grant_edge_busy"}, 32'(Busy_Out), 32'd1);
        check({tag, "_grant_edge_nz"},   32'(Grant_Out != 2'b00), 32'd1);
        if (drop_after == 1) Req_In = 2'b00;
        step();
        sb_check(tag);
        if (drop_after == 2) Req_In = 2'b00;
        for (int k = 1; k < H; k++) begin
            step();
            check({tag, "_hold_done"}, 32'(Done_Out), 32'd0);
        end
        step();
        check({tag, "_done"},       32'(Done_Out), 32'd1);
        check({tag, "_done_grant"}, 32'(Grant_Out), 32'd0);
        check({tag, "_done_busy"},  32'(Busy_Out), 32'd0);
    endtask

    task automatic pulse_reset();
        Reset_In = 1'b1;
        #1;
        Reset_In = 1'b0;
        m_ptr = 1'b0;
        sbq.delete();
    endtask

    initial begin
        logic [1:0] eg [6];
        logic       ed [6];
        logic [1:0] rr_g [3];
        eg = '{2'b01, 2'b01, 2'b00, 2'b01, 2'b01, 2'b00};
        ed = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};

        Reset_In = 1'b1; Req_In = 2'b11; Data0_In = 8'hFF; Data1_In = 8'hEE;
        req1 = 2'b00; d1_0 = 8'h77; d1_1 = 8'h88;
        step();
        step();
        check("rst_grant", 32'(Grant_Out), 32'd0);
        check("rst_data",  32'(Parallel_Data_Out), 32'd0);
        check("rst_owner", 32'(Owner_Out), 32'd0);
        check("rst_done",  32'(Done_Out), 32'd0);
        check("rst_busy",  32'(Busy_Out), 32'd0);
        check("rst_grant1", 32'(grant1), 32'd0);

        // Lone requester 0, request withdrawn during LOAD
        Req_In = 2'b00;
        Reset_In = 1'b0;
        txn("lone0", 2'b01, 8'hA5, 8'h5A, 1);
        step();
        check("idle_grant", 32'(Grant_Out), 32'd0);
        check("idle_busy",  32'(Busy_Out), 32'd0);
        check("idle_done",  32'(Done_Out), 32'd0);
        check("idle_data_held",  32'(Parallel_Data_Out), 32'hA5);
        check("idle_owner_held", 32'(Owner_Out), 32'd0);

        // Continuous simultaneous requests from a fresh pointer
        pulse_reset();
`ifdef PIPO_ARB_ROUND_ROBIN_EN
        rr_g = '{2'b01, 2'b10, 2'b01};
`else
        rr_g = '{2'b01, 2'b01, 2'b01};
`endif
        for (int i = 0; i < 3; i++) begin
            Req_In = 2'b11; Data0_In = 8'h11; Data1_In = 8'h22;
            step();
            check("tie_grant", 32'(Grant_Out), 32'(rr_g[i]));
            step();
            check("tie_data", 32'(Parallel_Data_Out), rr_g[i][1] ? 32'h22 : 32'h11);
            step();
            step();
            check("tie_done", 32'(Done_Out), 32'd1);
        end
        m_ptr = 1'b1;
`ifndef PIPO_ARB_ROUND_ROBIN_EN
        m_ptr = 1'b0;
`endif
        txn("tie4", 2'b11, 8'h11, 8'h22, 0);

        // Requester 1 drops its request in HOLD
        Req_In = 2'b00;
        step();
        txn("drop1", 2'b10, 8'h0F, 8'hC3, 2);
        step();
        check("drop1_data_held",  32'(Parallel_Data_Out), 32'hC3);
        check("drop1_owner_held", 32'(Owner_Out), 32'd1);

        // Reset pulse between edges in HOLD abandons the transaction
        Req_In = 2'b01; Data0_In = 8'h3C; Data1_In = 8'hC3;
        push_exp(2'b01);
        step();
        check("abort_grant", 32'(Grant_Out), 32'b01);
        step();
        sb_check("abort_load");
        #2;
        Reset_In = 1'b1;
        #1;
        check("abort_rst_grant", 32'(Grant_Out), 32'd0);
        check("abort_rst_data",  32'(Parallel_Data_Out), 32'd0);
        check("abort_rst_owner", 32'(Owner_Out), 32'd0);
        check("abort_rst_busy",  32'(Busy_Out), 32'd0);
        check("abort_rst_done",  32'(Done_Out), 32'd0);
        Data0_In = 8'h44; Data1_In = 8'h55;
        pulse_reset();
        txn("post_rst", 2'b11, 8'h44, 8'h55, 0);
        check("post_rst_owner", 32'(Owner_Out), 32'd0);
        Req_In = 2'b00;

        // HOLD_CYCLES=1 instance under a continuous lone request
        req1 = 2'b01;
        for (int i = 0; i < 6; i++) begin
            step();
            check("h1_grant", 32'(grant1), 32'(eg[i]));
            check("h1_done",  32'(done1), 32'(ed[i]));
            check("h1_busy",  32'(busy1), 32'(eg[i] != 2'b00));
            if (i == 1 || i == 4) check("h1_data", 32'(data1), 32'h77);
        end
        req1 = 2'b00;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
